// File: rtl/add1_arbiter.sv
// Round-robin arbiter that shares one increment-by-one datapath among NREQ requesters.
// Optional carry_out port is enabled by defining ADD1_ARBITER_CARRY_EN.
module add1_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] operand,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      result,
  output logic [IDW-1:0]        result_id,
  output logic                  result_valid,
  input  logic                  result_ready,
`ifdef ADD1_ARBITER_CARRY_EN
  output logic                  carry_out,
`endif
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] opReg_q, opReg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDW-1:0]   resultId_q, resultId_d;
  logic [IDW-1:0]   last_q, last_d;
  logic             resultValid_q, resultValid_d;
`ifdef ADD1_ARBITER_CARRY_EN
  logic             carry_q, carry_d;
`endif

  logic found;
  int   winIdx;
  int   scanIdx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      opReg_q       <= '0;
      result_q      <= '0;
      resultId_q    <= '0;
      last_q        <= IDW'(NREQ - 1);
      resultValid_q <= 1'b0;
`ifdef ADD1_ARBITER_CARRY_EN
      carry_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      opReg_q       <= opReg_d;
      result_q      <= result_d;
      resultId_q    <= resultId_d;
      last_q        <= last_d;
      resultValid_q <= resultValid_d;
`ifdef ADD1_ARBITER_CARRY_EN
      carry_q       <= carry_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = '0;
    opReg_d       = opReg_q;
    result_d      = result_q;
    resultId_d    = resultId_q;
    last_d        = last_q;
    resultValid_d = resultValid_q;
`ifdef ADD1_ARBITER_CARRY_EN
    carry_d       = carry_q;
`endif
    found   = 1'b0;
    winIdx  = 0;
    scanIdx = 0;

    // Scan starts just after the last winner so the previous owner ends up last.
    for (int i = 1; i <= NREQ; i++) begin
      scanIdx = (int'(last_q) + i) % NREQ;
      if (!found && req[scanIdx]) begin
        found  = 1'b1;
        winIdx = scanIdx;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          opReg_d    = operand[winIdx*WIDTH +: WIDTH];
          gnt_d      = NREQ'(1) << winIdx;
          resultId_d = IDW'(winIdx);
          last_d     = IDW'(winIdx);
          state_d    = COMPUTE;
        end
      end
      COMPUTE: begin
`ifdef ADD1_ARBITER_CARRY_EN
        {carry_d, result_d} = {1'b0, opReg_q} + (WIDTH+1)'(1);
`else
        result_d = opReg_q + WIDTH'(1);
`endif
        resultValid_d = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        if (result_ready) begin
          resultValid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt          = gnt_q;
  assign result       = result_q;
  assign result_id    = resultId_q;
  assign result_valid = resultValid_q;
  assign busy         = (state_q != IDLE);
`ifdef ADD1_ARBITER_CARRY_EN
  assign carry_out    = carry_q;
`endif

endmodule

// File: tb/tb_add1_arbiter.sv
// Directed self-checking bench for add1_arbiter; inputs change and outputs are sampled on the falling edge.
// Carry checks are compiled in only when ADD1_ARBITER_CARRY_EN is defined.
module tb_add1_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] operand;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      result;
  logic [1:0]            result_id;
  logic                  result_valid;
  logic                  result_ready;
  logic                  busy;
`ifdef ADD1_ARBITER_CARRY_EN
  logic                  carry_out;
`endif

  int checkCount = 0;
  int passCount  = 0;

  add1_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .operand      (operand),
    .gnt          (gnt),
    .result       (result),
    .result_id    (result_id),
    .result_valid (result_valid),
    .result_ready (result_ready),
`ifdef ADD1_ARBITER_CARRY_EN
    .carry_out    (carry_out),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] reqVec, input logic [WIDTH-1:0] op0,
                               input logic [WIDTH-1:0] op1, input logic [WIDTH-1:0] op2,
                               input logic [WIDTH-1:0] op3, input logic ready);
    req          = reqVec;
    operand      = {op3, op2, op1, op0};
    result_ready = ready;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".gnt"},   32'(gnt), 0);
    checkOutput({tag, ".res"},   32'(result), 0);
    checkOutput({tag, ".id"},    32'(result_id), 0);
    checkOutput({tag, ".valid"}, 32'(result_valid), 0);
    checkOutput({tag, ".busy"},  32'(busy), 0);
  endtask

  // One full transaction from IDLE with ready held high: grant, result, back to idle.
  task automatic runSingle(input string tag, input logic [NREQ-1:0] reqVec, input int idx,
                           input logic [WIDTH-1:0] op, input logic [WIDTH-1:0] expRes, input int expCarry);
    logic [WIDTH-1:0] ops [NREQ];
    for (int i = 0; i < NREQ; i++) ops[i] = 8'hA5;
    ops[idx] = op;
    applyStimulus(reqVec, ops[0], ops[1], ops[2], ops[3], 1'b1);
    @(negedge clk);
    checkOutput({tag, ".gnt"}, 32'(gnt), 32'(1 << idx));
    checkOutput({tag, ".busy"}, 32'(busy), 1);
    req = '0;
    @(negedge clk);
    checkOutput({tag, ".valid"}, 32'(result_valid), 1);
    checkOutput({tag, ".res"}, 32'(result), 32'(expRes));
    checkOutput({tag, ".id"}, 32'(result_id), 32'(idx));
    checkOutput({tag, ".gntlow"}, 32'(gnt), 0);
`ifdef ADD1_ARBITER_CARRY_EN
    checkOutput({tag, ".carry"}, 32'(carry_out), 32'(expCarry));
`else
    if (expCarry < 0) $display("[TB] unexpected carry argument");
`endif
    @(negedge clk);
    checkOutput({tag, ".idleValid"}, 32'(result_valid), 0);
    checkOutput({tag, ".idleBusy"}, 32'(busy), 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] expGnt [5];
    logic [WIDTH-1:0] expRes [5];
    int expId [5];

    applyStimulus('0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    doReset();
    checkResetState("reset");

    runSingle("single0", 4'b0001, 0, 8'd0, 8'd1, 0);
    runSingle("req2a", 4'b0100, 2, 8'd127, 8'd128, 0);
    runSingle("req2b", 4'b0100, 2, 8'd254, 8'd255, 0);
    runSingle("wrap1", 4'b0010, 1, 8'd255, 8'd0, 1);
    runSingle("plain1", 4'b0010, 1, 8'd35, 8'd36, 0);

    // All four requesters held: grants must rotate 0,1,2,3,0 after a reset.
    doReset();
    expGnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    expRes = '{8'd11, 8'd21, 8'd31, 8'd41, 8'd11};
    expId  = '{0, 1, 2, 3, 0};
    applyStimulus(4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      checkOutput($sformatf("rr%0d.gnt", t), 32'(gnt), 32'(expGnt[t]));
      @(negedge clk);
      checkOutput($sformatf("rr%0d.res", t), 32'(result), 32'(expRes[t]));
      checkOutput($sformatf("rr%0d.id", t), 32'(result_id), 32'(expId[t]));
      checkOutput($sformatf("rr%0d.valid", t), 32'(result_valid), 1);
      @(negedge clk);
      checkOutput($sformatf("rr%0d.idle", t), 32'(busy), 0);
      if (t == 4) req = '0;
    end

    // Backpressure: requester 3 completes while requester 0 waits behind a stalled consumer.
    applyStimulus(4'b1000, 8'd10, 8'd20, 8'd30, 8'd183, 1'b0);
    @(negedge clk);
    checkOutput("bp.gnt", 32'(gnt), 32'b1000);
    req = 4'b0001;
    @(negedge clk);
    checkOutput("bp.valid", 32'(result_valid), 1);
    checkOutput("bp.res", 32'(result), 184);
    checkOutput("bp.id", 32'(result_id), 3);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d.valid", s), 32'(result_valid), 1);
      checkOutput($sformatf("bp%0d.res", s), 32'(result), 184);
      checkOutput($sformatf("bp%0d.id", s), 32'(result_id), 3);
      checkOutput($sformatf("bp%0d.gnt", s), 32'(gnt), 0);
      checkOutput($sformatf("bp%0d.busy", s), 32'(busy), 1);
    end
    result_ready = 1'b1;
    @(negedge clk);
    checkOutput("bpAcc.valid", 32'(result_valid), 0);
    checkOutput("bpAcc.busy", 32'(busy), 0);
    checkOutput("bpAcc.gnt", 32'(gnt), 0);
    @(negedge clk);
    checkOutput("bpNext.gnt", 32'(gnt), 32'b0001);
    req = '0;
    @(negedge clk);
    checkOutput("bpNext.res", 32'(result), 11);
    checkOutput("bpNext.id", 32'(result_id), 0);
    @(negedge clk);
    checkOutput("bpNext.idle", 32'(busy), 0);

    // Reset while requester 2 is in COMPUTE must discard its transaction.
    applyStimulus(4'b0100, 8'd1, 8'd2, 8'd50, 8'd4, 1'b1);
    @(negedge clk);
    checkOutput("abort.gnt", 32'(gnt), 32'b0100);
    req   = '0;
    reset = 1'b1;
    @(negedge clk);
    checkResetState("abort");
`ifdef ADD1_ARBITER_CARRY_EN
    checkOutput("abort.carry", 32'(carry_out), 0);
`endif
    reset = 1'b0;
    applyStimulus(4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    @(negedge clk);
    checkOutput("post.gnt", 32'(gnt), 32'b0001);
    checkOutput("post.valid", 32'(result_valid), 0);
    req = '0;
    @(negedge clk);
    checkOutput("post.res", 32'(result), 11);
    checkOutput("post.id", 32'(result_id), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
